// File: rtl/opb_p2s_pkg.sv
// Shared definitions for the PPC-to-fabric OPB register: FSM encoding, decode bit, STATUS layout.
// Pure declarations and helper functions; no clocked logic.
// Not applicable: no flow control lives here.
package opb_p2s_pkg;

  // Bus-side handshake FSM, kept as plain constants for legacy tool compatibility
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACK  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  // OPB (big-endian) bit of the address that selects STATUS (offset 0x4) over DATA (offset 0x0)
  localparam int SEL_ABUS_BIT = 29;

  // STATUS word layout, user (little-endian) numbering
  localparam int STAT_VLD     = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_OCC_LSB = 2;
  localparam int STAT_OCC_W   = 3;

  // Byte-lane merge; be[3] covers bits 31:24, which is OPB BE[0] / DBus[0:7]
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Assemble the STATUS read word
  function automatic logic [31:0] status_word(input logic                  vld,
                                              input logic                  ovr,
                                              input logic [STAT_OCC_W-1:0] occ);
    logic [31:0] r;
    r = '0;
    r[STAT_VLD] = vld;
    r[STAT_OVR] = ovr;
    r[STAT_OCC_LSB +: STAT_OCC_W] = occ;
    return r;
  endfunction

endpackage

// File: rtl/opb_p2s_fifo.sv
// Small synchronous FIFO with occupancy count; only compiled when OPB_P2S_FIFO_EN is defined.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens on the same edge.
`ifdef OPB_P2S_FIFO_EN
module opb_p2s_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_dat = mem[rd_ptr_q];
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Pointer and count bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + (do_push ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (do_pop  ? AW'(1) : AW'(0));
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed since reads are gated by the count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_dat;
  end

endmodule
`endif

// File: rtl/opb_register_ppc2simulink_hs.sv
// OPB slave register passing PPC-written words to fabric over valid/ready (DATA at +0x0, STATUS at +0x4).
// Latency: xferAck one cycle after a decoded select; a written word is valid to the fabric the cycle after ack.
// Backpressure: 1-entry holding reg overwrites and flags overrun; with OPB_P2S_FIFO_EN a full FIFO answers Sl_retry.
module opb_register_ppc2simulink_hs
  import opb_p2s_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0109_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0109_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter int          C_FIFO_DEPTH = 4
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_retry,
  output logic                    Sl_errAck,
  output logic                    Sl_toutSup,
  output logic [31:0]             user_data_out,
  output logic                    user_data_valid,
  input  logic                    user_data_ready
);

  state_t      state_q, state_d;
  logic        stat_sel_q, stat_sel_d;
  logic        rnw_q, rnw_d;
  logic [31:0] shadow_q, shadow_d;
  logic        ovr_q, ovr_d;

  logic [31:0] abus_u, dbus_u, merged, rd_dat;
  logic [3:0]  be_u;
  logic        hit, in_ack, wr_data, wr_stat, rd_ack;
  logic        pop, push, retry, ovr_set, ovr_clr;
  logic        q_vld;
  logic [31:0] q_dat;
  logic [STAT_OCC_W-1:0] occ;
  logic        unused_ok;

  // Packed [0:31] bus assigns straight across: OPB bit i lands on user bit 31-i
  assign abus_u = 32'(OPB_ABus);
  assign dbus_u = 32'(OPB_DBus);
  assign be_u   = OPB_BE;

  assign hit     = OPB_select && (abus_u >= C_BASEADDR) && (abus_u <= C_HIGHADDR);
  assign in_ack  = (state_q == ST_ACK);
  assign wr_data = in_ack & ~rnw_q & ~stat_sel_q;
  assign wr_stat = in_ack & ~rnw_q &  stat_sel_q;
  assign rd_ack  = in_ack &  rnw_q;
  assign merged  = be_merge(shadow_q, dbus_u, be_u);
  assign pop     = q_vld & user_data_ready;
  assign push    = wr_data & ~retry;
  assign ovr_clr = wr_stat & dbus_u[STAT_OVR];

  assign Sl_xferAck      = in_ack & ~retry;
  assign Sl_retry        = retry;
  assign Sl_errAck       = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_valid = q_vld;
  assign user_data_out   = q_dat;

  // Read mux; the bus is driven only while acking a read
  always_comb begin
    rd_dat = '0;
    if (rd_ack) rd_dat = stat_sel_q ? status_word(q_vld, ovr_q, occ) : shadow_q;
  end
  assign Sl_DBus = C_OPB_DWIDTH'(rd_dat);

  // Handshake FSM: one wait state, a single ack cycle, then hold off until the master drops select
  always_comb begin
    state_d    = state_q;
    stat_sel_d = stat_sel_q;
    rnw_d      = rnw_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d    = ST_ACK;
          stat_sel_d = OPB_ABus[SEL_ABUS_BIT];
          rnw_d      = OPB_RNW;
        end
      end
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!OPB_select) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow follows every accepted DATA write; overrun is sticky with set winning over clear
  always_comb begin
    shadow_d = push ? merged : shadow_q;
    ovr_d    = ovr_set | (ovr_q & ~ovr_clr);
  end

  // Bus-side state registers
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q    <= ST_IDLE;
      stat_sel_q <= 1'b0;
      rnw_q      <= 1'b0;
      shadow_q   <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stat_sel_q <= stat_sel_d;
      rnw_q      <= rnw_d;
      shadow_q   <= shadow_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef OPB_P2S_FIFO_EN
  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_dat;

  opb_p2s_fifo #(
    .DEPTH (C_FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .push     (push),
    .push_dat (merged),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A full FIFO refuses the write unless the fabric frees a slot on the same edge
  assign retry   = wr_data & fifo_full & ~pop;
  assign ovr_set = retry;
  assign q_vld   = ~fifo_empty;
  assign q_dat   = fifo_empty ? 32'h0 : fifo_dat;
  assign occ     = STAT_OCC_W'(fifo_cnt);
  assign unused_ok = ^{OPB_seqAddr, (C_FAMILY == "virtex5")};
`else
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_dat_q, hold_dat_d;

  // Writes never stall; a push onto an unconsumed word replaces it and flags overrun
  assign retry   = 1'b0;
  assign ovr_set = push & hold_vld_q & ~pop;
  assign q_vld   = hold_vld_q;
  assign q_dat   = hold_dat_q;
  assign occ     = {{(STAT_OCC_W-1){1'b0}}, hold_vld_q};
  assign unused_ok = ^{OPB_seqAddr, (C_FAMILY == "virtex5"), (C_FIFO_DEPTH != 0)};

  // Holding register: a push always loads, a pop alone empties it
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (push) begin
      hold_vld_d = 1'b1;
      hold_dat_d = merged;
    end else if (pop) begin
      hold_vld_d = 1'b0;
    end
  end

  // Holding register state
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end
`endif

endmodule

// File: tb/tb_opb_register_ppc2simulink_hs.sv
// Bench for opb_register_ppc2simulink_hs: table of OPB transfers plus hand sequences for corner cases.
// Expected fabric words are queued in a scoreboard on each accepted DATA write and checked on pop.
// Define OPB_P2S_FIFO_EN for both bench and RTL to exercise the FIFO build.
module tb_opb_register_ppc2simulink_hs;

`ifdef OPB_P2S_FIFO_EN
  localparam int QCAP = 4;
`else
  localparam int QCAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus, dbus, sl_dbus;
  logic [0:3]  be;
  logic        rnw, sel, seqaddr;
  logic        ack, retry_o, errack, tout;
  logic [31:0] udo;
  logic        uvld, urdy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mq[$];
  logic [31:0] m_shadow;
  bit          m_ovr;
  bit          mon_en;

  always #5 clk = ~clk;

  opb_register_ppc2simulink_hs dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seqaddr),
    .Sl_DBus         (sl_dbus),
    .Sl_xferAck      (ack),
    .Sl_retry        (retry_o),
    .Sl_errAck       (errack),
    .Sl_toutSup      (tout),
    .user_data_out   (udo),
    .user_data_valid (uvld),
    .user_data_ready (urdy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [2:0] occ;
    occ = 3'(mq.size());
    return {27'd0, occ, m_ovr, (mq.size() != 0)};
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic m_push(input logic [31:0] w);
    if (mq.size() >= QCAP) begin
      mq[mq.size()-1] = w;
      m_ovr = 1'b1;
    end else begin
      mq.push_back(w);
    end
  endtask

  // Fabric-side scoreboard: valid must track the model, popped words must come out in order
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", {31'd0, uvld}, {31'd0, (mq.size() != 0)});
      if (uvld && urdy && mq.size() != 0) begin
        chk("pop_data", udo, mq[0]);
        void'(mq.pop_front());
      end
    end
  end

  // One complete OPB transfer; called #1 after a rising edge
  task automatic bus_op(input bit is_rd, input logic [31:0] addr, input logic [3:0] be_i,
                        input logic [31:0] wd, input bit exp_hit, input bit rdy_in_ack,
                        output logic [31:0] rd, output bit retried);
    int n;
    bit got, exp_retry;
    rd = '0; retried = 1'b0; got = 1'b0; n = 0; exp_retry = 1'b0;
    abus = addr; dbus = is_rd ? 32'h0 : wd; be = be_i; rnw = is_rd; sel = 1'b1;
    while (!got && n < 4) begin
      @(posedge clk); #1;
      n++;
      if (ack || retry_o) got = 1'b1;
    end
    chk("hit", {31'd0, got}, {31'd0, exp_hit});
    if (got) begin
      chk("ack_latency", n, 1);
`ifdef OPB_P2S_FIFO_EN
      exp_retry = !is_rd && !addr[2] && (mq.size() >= QCAP) && !(urdy || rdy_in_ack);
`endif
      chk("retry", {31'd0, retry_o}, {31'd0, exp_retry});
      chk("xferack", {31'd0, ack}, {31'd0, !exp_retry});
      retried = retry_o;
      rd = sl_dbus;
      if (!is_rd) chk("dbus_in_write_ack", sl_dbus, 32'h0);
      if (rdy_in_ack) urdy = 1'b1;
      @(posedge clk); #1;
      if (!is_rd) begin
        if (!addr[2]) begin
          if (exp_retry) m_ovr = 1'b1;
          else begin
            m_shadow = m_merge(m_shadow, wd, be_i);
            m_push(m_shadow);
          end
        end else if (wd[1]) begin
          m_ovr = 1'b0;
        end
      end
      chk("no_ack_in_wait", {30'd0, ack, retry_o}, 32'h0);
      chk("dbus_in_wait", sl_dbus, 32'h0);
    end
    sel = 1'b0; rnw = 1'b0; abus = '0; dbus = '0; be = '0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          hit;
    bit          use_exp;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tv[14];
    logic [31:0] rd, exp_rd;
    bit          rt;
    int          n;

`ifdef OPB_P2S_FIFO_EN
    localparam logic [31:0] ST_AFTER_2 = 32'h9;
    localparam logic [31:0] ST_AFTER_CLR = 32'h9;
`else
    localparam logic [31:0] ST_AFTER_2 = 32'h7;
    localparam logic [31:0] ST_AFTER_CLR = 32'h5;
`endif
    tv[0]  = '{0, 32'h0109_0000, 4'b1000, 32'h1234_5678, 1, 0, 32'h0};
    tv[1]  = '{1, 32'h0109_0000, 4'h0,    32'h0,         1, 1, 32'h12AD_BEEF};
    tv[2]  = '{1, 32'h0109_0004, 4'h0,    32'h0,         1, 1, ST_AFTER_2};
    tv[3]  = '{0, 32'h0109_0004, 4'hF,    32'h0000_0002, 1, 0, 32'h0};
    tv[4]  = '{1, 32'h0109_0004, 4'h0,    32'h0,         1, 1, ST_AFTER_CLR};
    tv[5]  = '{0, 32'h0109_0100, 4'hF,    32'hBAD0_0001, 0, 0, 32'h0};
    tv[6]  = '{0, 32'h0108_FFFC, 4'hF,    32'hBAD0_0002, 0, 0, 32'h0};
    tv[7]  = '{0, 32'h0109_0000, 4'b0001, 32'h0000_00AA, 1, 0, 32'h0};
    tv[8]  = '{1, 32'h0109_0008, 4'h0,    32'h0,         1, 1, 32'h12AD_BEAA};
    tv[9]  = '{1, 32'h0109_000C, 4'h0,    32'h0,         1, 0, 32'h0};
    tv[10] = '{0, 32'h0109_00F4, 4'hF,    32'hFFFF_FFFF, 1, 0, 32'h0};
    tv[11] = '{1, 32'h0109_0004, 4'h0,    32'h0,         1, 0, 32'h0};
    tv[12] = '{0, 32'h0109_0000, 4'b0110, 32'h00CD_EF00, 1, 0, 32'h0};
    tv[13] = '{1, 32'h0109_00FC, 4'h0,    32'h0,         1, 0, 32'h0};

    rst_n = 1'b0; abus = '0; dbus = '0; be = '0; rnw = 1'b0; sel = 1'b0; seqaddr = 1'b0;
    urdy = 1'b0; mon_en = 1'b0; m_shadow = '0; m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_xferack", {31'd0, ack}, 32'h0);
    chk("rst_retry", {31'd0, retry_o}, 32'h0);
    chk("rst_errack", {31'd0, errack}, 32'h0);
    chk("rst_toutsup", {31'd0, tout}, 32'h0);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_udata", udo, 32'h0);
    chk("rst_uvalid", {31'd0, uvld}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // First full-word write
    bus_op(0, 32'h0109_0000, 4'hF, 32'hDEAD_BEEF, 1, 0, rd, rt);
    chk("first_valid", {31'd0, uvld}, 32'h1);
    chk("first_data", udo, 32'hDEAD_BEEF);

    // Table of transfers with the fabric stalled
    for (int i = 0; i < 14; i++) begin
      if (tv[i].is_rd) exp_rd = tv[i].addr[2] ? m_status() : m_shadow;
      bus_op(tv[i].is_rd, tv[i].addr, tv[i].be, tv[i].wd, tv[i].hit, 0, rd, rt);
      if (tv[i].is_rd) begin
        chk($sformatf("vec%0d_read", i), rd, tv[i].use_exp ? tv[i].exp : exp_rd);
        if (tv[i].use_exp) chk($sformatf("vec%0d_model", i), rd, exp_rd);
      end
    end

    // Drain whatever is held, then clear overrun and expect an all-zero STATUS
    urdy = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    urdy = 1'b0;
    chk("drain_empty", {31'd0, uvld}, 32'h0);
    bus_op(0, 32'h0109_0004, 4'hF, 32'h0000_0002, 1, 0, rd, rt);
    bus_op(1, 32'h0109_0004, 4'h0, 32'h0, 1, 0, rd, rt);
    chk("status_empty", rd, 32'h0);

    // Push and pop on the same edge: word replaced cleanly, no overrun
    bus_op(0, 32'h0109_0000, 4'hF, 32'h1111_1111, 1, 0, rd, rt);
    bus_op(0, 32'h0109_0000, 4'hF, 32'h2222_2222, 1, 1, rd, rt);
    chk("pushpop_then_empty", {31'd0, uvld}, 32'h0);
    urdy = 1'b0;
    bus_op(1, 32'h0109_0004, 4'h0, 32'h0, 1, 0, rd, rt);
    chk("pushpop_status", rd, 32'h0);

`ifdef OPB_P2S_FIFO_EN
    // Overfill the FIFO: fifth write is retried and flags overrun
    for (int i = 0; i < 5; i++) begin
      bus_op(0, 32'h0109_0000, 4'hF, 32'hA000_0000 + 32'(i), 1, 0, rd, rt);
      chk($sformatf("fill%0d_retry", i), {31'd0, rt}, {31'd0, (i == 4)});
    end
    bus_op(1, 32'h0109_0004, 4'h0, 32'h0, 1, 0, rd, rt);
    chk("full_status", rd, 32'h13);
    bus_op(1, 32'h0109_0000, 4'h0, 32'h0, 1, 0, rd, rt);
    chk("retry_shadow_kept", rd, 32'hA000_0003);
    urdy = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    urdy = 1'b0;
    chk("fifo_drained", {31'd0, uvld}, 32'h0);
    bus_op(0, 32'h0109_0004, 4'hF, 32'h0000_0002, 1, 0, rd, rt);
`endif

    // Reset asserted in the middle of a read ack
    bus_op(0, 32'h0109_0000, 4'hF, 32'h3333_3333, 1, 0, rd, rt);
    abus = 32'h0109_0000; rnw = 1'b1; sel = 1'b1; n = 0;
    while (!ack && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_reset_ack", {31'd0, ack}, 32'h1);
    chk("pre_reset_dbus", sl_dbus, m_shadow);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_xferack", {31'd0, ack}, 32'h0);
    chk("midrst_dbus", sl_dbus, 32'h0);
    chk("midrst_uvalid", {31'd0, uvld}, 32'h0);
    chk("midrst_udata", udo, 32'h0);
    sel = 1'b0; rnw = 1'b0; abus = '0;
    mq.delete(); m_shadow = '0; m_ovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    bus_op(1, 32'h0109_0000, 4'h0, 32'h0, 1, 0, rd, rt);
    chk("post_reset_shadow", rd, 32'h0);
    bus_op(1, 32'h0109_0004, 4'h0, 32'h0, 1, 0, rd, rt);
    chk("post_reset_status", rd, 32'h0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
